// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: state encoding,
// frame geometry constants and the byte-acceptance helper.
package prog_loader_pkg;

  localparam int HEADER_BYTES = 4;
  localparam int COUNT_BYTES  = 2;
  localparam int WORD_BYTES   = 4;
  localparam int ADDR_STEP    = 4;
  localparam int LANE_W       = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    HDR_CNT,
    HDR_ADDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  // States in which the loader presents in_ready to the host link.
  function automatic logic accepts_bytes(input state_t s);
    return (s == HDR_CNT) || (s == HDR_ADDR) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus ram data-port write bundle seen by the loader.
// slave = loader side, master = host/memory side.
interface prog_loader_if #(
  parameter int ADDRESS_BITS = 16
);

  logic                    in_valid;
  logic [7:0]              in_data;
  logic                    in_ready;
  logic                    mem_wEn;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [31:0]             mem_write_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_wEn,
    input  mem_address,
    input  mem_write_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_wEn,
    output mem_address,
    output mem_write_data
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-lane packer: lane counter, 32-bit word assembly and a
// word_valid pulse on the transfer that completes a word.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [LANE_W-1:0] lane,
  output logic [31:0]       word_next,
  output logic              word_valid
);

  logic [LANE_W-1:0] lane_reg;
  logic [31:0]       word_reg;

  // word_next already contains the byte being transferred this cycle, so the
  // parent can register a complete word on the same edge as the last byte.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (byte_valid && lane_reg == LANE_W'(gi))
                                    ? byte_data : word_reg[8*gi +: 8];
    end
  endgenerate

  assign lane       = lane_reg;
  assign word_valid = byte_valid && (lane_reg == LANE_W'(WORD_BYTES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_reg <= '0;
      word_reg <= '0;
    end else if (byte_valid) begin
      lane_reg <= lane_reg + LANE_W'(1);
      word_reg <= word_next;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: parses COUNT/ADDR header, writes LE words
// to ram and releases core reset on success. Optional trailing XOR checksum
// byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  prog_loader_if.slave            bus,
  output logic                    core_reset,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESS_BITS-1:0] words_written
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = CHK;
`else
  localparam state_t FINAL_STATE = DONE;
`endif

  state_t state_reg, state_next;

  logic                    in_ready_reg;
  logic                    mem_wen_reg;
  logic [ADDRESS_BITS-1:0] mem_address_reg;
  logic [31:0]             mem_write_data_reg;
  logic                    core_reset_reg;
  logic                    done_reg;
  logic                    error_reg;
  logic [ADDRESS_BITS-1:0] words_written_reg;
  logic [ADDRESS_BITS-1:0] count_reg;
  logic [ADDRESS_BITS-1:0] addr_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              xor_reg;
`endif

  logic                    transfer;
  logic                    pack_valid;
  logic                    word_valid;
  logic                    hdr_done;
  logic [LANE_W-1:0]       lane;
  logic [31:0]             word_next;
  logic [ADDRESS_BITS-1:0] hdr_count;
  logic [ADDRESS_BITS-1:0] hdr_addr;

  assign transfer   = bus.in_valid & in_ready_reg;
  assign pack_valid = transfer & (state_reg != CHK);

  // The header travels through the packer as one word: {ADDR, COUNT}.
  assign hdr_done  = pack_valid && (state_reg == HDR_ADDR)
                     && (lane == LANE_W'(HEADER_BYTES - 1));
  assign hdr_count = ADDRESS_BITS'(word_next[15:0]);
  assign hdr_addr  = ADDRESS_BITS'(word_next[31:16]);

  prog_loader_byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (pack_valid),
    .byte_data  (bus.in_data),
    .lane       (lane),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR_CNT: begin
        if (pack_valid && lane == LANE_W'(COUNT_BYTES - 1)) begin
          state_next = HDR_ADDR;
        end
      end
      HDR_ADDR: begin
        if (hdr_done) begin
          if (word_next[17:16] != 2'b00) begin
            state_next = ERR;
          end else if (hdr_count == '0) begin
            state_next = FINAL_STATE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (words_written_reg == count_reg) ? FINAL_STATE : DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (transfer) begin
          state_next = (bus.in_data == xor_reg) ? DONE : ERR;
        end
      end
`endif
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= HDR_CNT;
      in_ready_reg       <= 1'b0;
      mem_wen_reg        <= 1'b0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= '0;
      core_reset_reg     <= 1'b1;
      done_reg           <= 1'b0;
      error_reg          <= 1'b0;
      words_written_reg  <= '0;
      count_reg          <= '0;
      addr_reg           <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_reg            <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= accepts_bytes(state_next);
      mem_wen_reg  <= (state_next == WRITE);

      if (hdr_done) begin
        count_reg <= hdr_count;
        addr_reg  <= hdr_addr;
      end

      // Word, address and count are latched on the edge entering WRITE so
      // they are all visible during the single strobe cycle.
      if (state_reg == DATA && word_valid) begin
        mem_address_reg    <= addr_reg;
        mem_write_data_reg <= word_next;
        words_written_reg  <= words_written_reg + ADDRESS_BITS'(1);
      end

      if (state_reg == WRITE) begin
        addr_reg <= addr_reg + ADDRESS_BITS'(ADDR_STEP);
      end

`ifdef LOADER_CHECKSUM_EN
      if (state_reg == DATA && transfer) begin
        xor_reg <= xor_reg ^ bus.in_data;
      end
`endif

      if (state_next == DONE) begin
        done_reg       <= 1'b1;
        core_reset_reg <= 1'b0;
      end
      if (state_next == ERR) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign bus.in_ready       = in_ready_reg;
  assign bus.mem_wEn        = mem_wen_reg;
  assign bus.mem_address    = mem_address_reg;
  assign bus.mem_write_data = mem_write_data_reg;
  assign core_reset         = core_reset_reg;
  assign done               = done_reg;
  assign error              = error_reg;
  assign words_written      = words_written_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of framed images plus hand-written
// reset and mid-load abort sequences. Honours LOADER_CHECKSUM_EN.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  prog_loader_if #(.ADDRESS_BITS(16)) bus ();

  prog_loader #(.ADDRESS_BITS(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .core_reset    (core_reset),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  typedef struct {
    string             name;
    logic [0:15][7:0]  bytes;
    int                nbytes;
    logic [7:0]        chk;
    bit                chk_applies;
    int                gap;
    int                exp_writes;
    logic [0:1][15:0]  exp_addr;
    logic [0:1][31:0]  exp_data;
    logic              exp_done;
    logic              exp_error;
    logic              exp_core_reset;
    logic [15:0]       exp_words;
  } vec_t;

`ifdef LOADER_CHECKSUM_EN
  localparam int NVEC = 6;
`else
  localparam int NVEC = 4;
`endif

  vec_t vecs [6];

  logic [15:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic        prev_wen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.mem_wEn === 1'b1) begin
      wr_addr.push_back(bus.mem_address);
      wr_data.push_back(bus.mem_write_data);
      $display("write addr=0x%04h data=0x%08h words_written=%0d",
               bus.mem_address, bus.mem_write_data, words_written);
      check("in_ready_low_in_write", {31'b0, bus.in_ready}, 32'd0);
      check("wen_single_cycle", {31'b0, prev_wen}, 32'd0);
    end
    prev_wen = bus.mem_wEn;
  end

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clock);
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("byte_accept", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},       {31'b0, bus.in_ready},   32'd0);
    check({tag, "_mem_wEn"},        {31'b0, bus.mem_wEn},    32'd0);
    check({tag, "_mem_address"},    {16'b0, bus.mem_address}, 32'd0);
    check({tag, "_mem_write_data"}, bus.mem_write_data,      32'd0);
    check({tag, "_core_reset"},     {31'b0, core_reset},     32'd1);
    check({tag, "_done"},           {31'b0, done},           32'd0);
    check({tag, "_error"},          {31'b0, error},          32'd0);
    check({tag, "_words_written"},  {16'b0, words_written},  32'd0);
  endtask

  task automatic run_vec(input int v);
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < vecs[v].nbytes; i++) begin
      send_byte(vecs[v].bytes[i], vecs[v].gap);
    end
`ifdef LOADER_CHECKSUM_EN
    if (vecs[v].chk_applies) send_byte(vecs[v].chk, vecs[v].gap);
`endif
    repeat (4) @(posedge clock);
    @(negedge clock);
    check({vecs[v].name, "_write_count"}, wr_addr.size(), vecs[v].exp_writes);
    for (int w = 0; w < vecs[v].exp_writes && w < wr_addr.size(); w++) begin
      check({vecs[v].name, "_write_addr"}, {16'b0, wr_addr[w]}, {16'b0, vecs[v].exp_addr[w]});
      check({vecs[v].name, "_write_data"}, wr_data[w], vecs[v].exp_data[w]);
    end
    check({vecs[v].name, "_done"},          {31'b0, done},          {31'b0, vecs[v].exp_done});
    check({vecs[v].name, "_error"},         {31'b0, error},         {31'b0, vecs[v].exp_error});
    check({vecs[v].name, "_core_reset"},    {31'b0, core_reset},    {31'b0, vecs[v].exp_core_reset});
    check({vecs[v].name, "_words_written"}, {16'b0, words_written}, {16'b0, vecs[v].exp_words});
    check({vecs[v].name, "_in_ready_end"},  {31'b0, bus.in_ready},  32'd0);
    $display("vec %0d %s: writes=%0d done=%0d error=%0d words=%0d",
             v, vecs[v].name, wr_addr.size(), done, error, words_written);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"two_words",
                {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 32'h0},
                12, 8'h90, 1'b1, 0, 2,
                {16'h0000, 16'h0004}, {32'h00000013, 32'h00100093},
                1'b1, 1'b0, 1'b0, 16'd2};
    vecs[1] = '{"zero_count",
                {8'h00, 8'h00, 8'h00, 8'h01, 96'h0},
                4, 8'h00, 1'b1, 0, 0,
                {16'h0000, 16'h0000}, {32'h0, 32'h0},
                1'b1, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{"misaligned",
                {8'h01, 8'h00, 8'h02, 8'h00, 96'h0},
                4, 8'h00, 1'b0, 0, 0,
                {16'h0000, 16'h0000}, {32'h0, 32'h0},
                1'b0, 1'b1, 1'b1, 16'd0};
    vecs[3] = '{"wrap_gaps",
                {8'h02, 8'h00, 8'hFC, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                 8'h01, 8'h02, 8'h03, 8'h04, 32'h0},
                12, 8'h04, 1'b1, 1, 2,
                {16'hFFFC, 16'h0000}, {32'hDDCCBBAA, 32'h04030201},
                1'b1, 1'b0, 1'b0, 16'd2};
    vecs[4] = '{"chk_good",
                {8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 64'h0},
                8, 8'h44, 1'b1, 0, 1,
                {16'h0000, 16'h0000}, {32'h44332211, 32'h0},
                1'b1, 1'b0, 1'b0, 16'd1};
    vecs[5] = '{"chk_bad",
                {8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 64'h0},
                8, 8'h45, 1'b1, 0, 1,
                {16'h0000, 16'h0000}, {32'h44332211, 32'h0},
                1'b0, 1'b1, 1'b1, 16'd1};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state and in_ready rising on the first edge after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("in_ready_before_first_edge", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clock);
    check("in_ready_after_release", {31'b0, bus.in_ready}, 32'd1);

    for (int v = 0; v < NVEC; v++) begin
      run_vec(v);
    end

    // Mid-load abort: 3-word image, reset after 6 payload bytes.
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    begin
      logic [7:0] abort_bytes [10];
      abort_bytes = '{8'h03, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      for (int i = 0; i < 10; i++) send_byte(abort_bytes[i], 0);
    end
    check("abort_writes_before_reset", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check("abort_first_addr", {16'b0, wr_addr[0]}, 32'h0200);
      check("abort_first_data", wr_data[0], 32'h04030201);
    end
    check("abort_words_before_reset", {16'b0, words_written}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("abort");
    $display("abort: reset applied mid-load after %0d write(s)", wr_addr.size());
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader.
- Receives a framed image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes each word into main memory through the data-port write signals (wEn/d_address/d_write_data).
- Holds the core in reset until the image is fully written; sits between an external host link and the ram data port, muxed in front of the core's store path.

Parameters:
- ADDRESS_BITS, 16, width of memory byte address and of word-count field.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  byte present on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- mem_wEn  output  1  one-cycle write strobe to ram data port
- mem_address  output  ADDRESS_BITS  byte address of write (word aligned)
- mem_write_data  output  32  word to write
- core_reset  output  1  hold core (fetch/regFile) in reset
- done  output  1  image loaded successfully (sticky)
- error  output  1  frame error (sticky)
- words_written  output  ADDRESS_BITS  count of words written so far

Behaviour:
- Frame format: COUNT (2 bytes, LE, number of words N), ADDR (2 bytes, LE, start byte address), then N words × 4 bytes LE; bytes beyond ADDRESS_BITS ignored.
- All outputs registered. Reset values: in_ready 0, mem_wEn 0, mem_address 0, mem_write_data 0, core_reset 1, done 0, error 0, words_written 0; FSM -> HDR_CNT, byte index 0.
- States: HDR_CNT, HDR_ADDR, DATA, WRITE, CHK (optional), DONE, ERR.
- in_ready = 1 in HDR_CNT, HDR_ADDR, DATA, CHK; 0 in WRITE, DONE, ERR. First cycle after reset release in_ready goes 1.
- 2-bit byte index selects byte lane; increments only on transfer; stalls (no state change) while in_valid=0.
- HDR_CNT: after 2nd byte -> HDR_ADDR.
- HDR_ADDR: after 2nd byte: if addr[1:0]≠0 -> ERR; else if N=0 -> CHK (if enabled) else DONE; else -> DATA.
- DATA: lane k of word ← byte k. On 4th byte transfer -> WRITE.
- WRITE (exactly 1 cycle): mem_wEn=1, mem_address=current addr, mem_write_data=assembled word; words_written+1; addr += 4 modulo 2^ADDRESS_BITS (wrap 0xFFFC -> 0x0000). Next: if words_written reaches N -> CHK/DONE, else DATA.
- Write throughput: at most 1 word per 5 cycles.
- mem_wEn is 0 in every other state/cycle; mem_address/mem_write_data hold last value.
- DONE: done=1, core_reset=0 from the cycle DONE is entered; sticky until reset.
- ERR: error=1, core_reset stays 1; sticky until reset; further bytes not accepted.
- Reset mid-load: immediate abort, all outputs to reset values, no partial write strobe; memory contents already written are not cleared.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- With: after the last word (or header when N=0), CHK state accepts 1 byte; it must equal XOR of all payload data bytes (header excluded, 0x00 when N=0). Match -> DONE, mismatch -> ERR.
- Without: CHK state absent; last WRITE (or header with N=0) -> DONE directly; no trailing byte consumed.

Decomposition:
- Shared package prog_loader_pkg: state encoding typedef, header length constant (4), word byte count (4), address step (4).
- One natural sub-module: byte_packer (byte-lane shift/assemble into 32-bit word, lane counter, word_valid pulse), instantiated once.

Test Plan:
- Bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 with in_valid continuous -> writes (0x0000, 0x00000013) then (0x0004, 0x00100093), one mem_wEn cycle each; done=1, core_reset=0, words_written=2.
- COUNT=0, ADDR=0x0100 -> no mem_wEn ever; done=1 after 4th byte (plus checksum 0x00 if enabled).
- ADDR=0x0002 -> error=1, no writes, core_reset stays 1, in_ready=0 thereafter.
- N=2, ADDR=0xFFFC, in_valid toggled every other cycle -> writes at 0xFFFC then 0x0000; data correct despite gaps; in_ready=0 during each WRITE cycle.
- Reset asserted after 6 payload bytes of a 3-word image -> outputs immediately at reset values; fresh full frame afterwards loads correctly.
- (LOADER_CHECKSUM_EN) 1-word image 11 22 33 44 with checksum 0x44 -> done; with 0x45 -> error, core_reset=1.
